// File: rtl/id_stage_seq.sv
// Decode-stage sequencer: classifies fetched instructions into an immediate
// format, drives the shared immediate extender and captures its result plus
// register fields into the ID/EX output register. A one-entry skid buffer
// keeps if_ready registered (no combinational path from ex_ready).
//
// state | meaning
// ------+------------------------------------------
// EMPTY | output register invalid, skid empty
// BUSY  | output register valid, skid empty
// FULL  | output register valid, skid holds one raw instruction
module id_stage_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_ready,
    input  logic            flush,
    output logic [2:0]      immsrc,
    output logic [24:0]     imm,
    input  logic [XLEN-1:0] immext_in,
    output logic            id_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_immext,
    output logic [4:0]      id_rd,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic            id_illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0]     skid_instr_q;
    logic [XLEN-1:0] skid_pc_q;
    logic [31:0]     src_instr;
    logic [XLEN-1:0] src_pc;
    logic            src_illegal;
    logic            accept;
    logic            consume;
    logic            load_out;
    logic            load_skid;

    // if_ready depends only on registered state and reset, never on ex_ready
    assign if_ready = !rst && (state_q != ST_FULL);
    assign accept   = if_valid && if_ready;
    assign consume  = id_valid && ex_ready;
    assign id_valid = (state_q != ST_EMPTY);

    // The skid entry has priority as load source; the extender is shared
    // between the fetch path and the skid path through this mux
    always_comb begin
        src_instr = if_instr;
        src_pc    = if_pc;
        if (state_q == ST_FULL) begin
            src_instr = skid_instr_q;
            src_pc    = skid_pc_q;
        end
    end

    // Opcode classification into extender format select
    always_comb begin
        immsrc      = 3'b111;
        src_illegal = 1'b0;
        case (src_instr[6:0])
            7'b0000011,
            7'b0010011,
            7'b1100111: immsrc = 3'b000;
            7'b0100011: immsrc = 3'b001;
            7'b1100011: immsrc = 3'b010;
            7'b1101111: immsrc = 3'b011;
            7'b0110111,
            7'b0010111: immsrc = 3'b100;
            7'b0110011: immsrc = 3'b111;
            default: begin
                immsrc      = 3'b111;
                src_illegal = 1'b1;
            end
        endcase
    end

    assign imm = src_instr[31:7];

    // Next-state and load-enable logic; flush overrides every transition
    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d  = ST_BUSY;
                    load_out = 1'b1;
                end
            end
            ST_BUSY: begin
                if (accept && consume) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (consume) begin
                    state_d  = ST_BUSY;
                    load_out = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_d   = ST_EMPTY;
            load_out  = 1'b0;
            load_skid = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Skid entry holds the raw word and PC; it is re-extended on the way out
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else if (load_skid) begin
            skid_instr_q <= if_instr;
            skid_pc_q    <= if_pc;
        end
    end

    // ID/EX output register, only written when the slot is free or consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc      <= '0;
            id_immext  <= '0;
            id_rd      <= '0;
            id_rs1     <= '0;
            id_rs2     <= '0;
            id_illegal <= 1'b0;
        end else if (load_out) begin
            id_pc      <= src_pc;
            id_immext  <= immext_in;
            id_rd      <= src_instr[11:7];
            id_rs1     <= src_instr[19:15];
            id_rs2     <= src_instr[24:20];
            id_illegal <= src_illegal;
        end
    end

endmodule

// File: tb/tb_id_stage_seq.sv
// Directed bench for id_stage_seq. The bench provides the immediate extender
// that the stage drives; expected results are hand-computed constants.
module tb_id_stage_seq;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        flush;
    logic [2:0]  immsrc;
    logic [24:0] imm;
    logic [31:0] immext_in;
    logic        id_valid;
    logic        ex_ready;
    logic [31:0] id_pc;
    logic [31:0] id_immext;
    logic [4:0]  id_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_illegal;

    int vectors;
    int miscompares;

    id_stage_seq #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_ready   (if_ready),
        .flush      (flush),
        .immsrc     (immsrc),
        .imm        (imm),
        .immext_in  (immext_in),
        .id_valid   (id_valid),
        .ex_ready   (ex_ready),
        .id_pc      (id_pc),
        .id_immext  (id_immext),
        .id_rd      (id_rd),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_illegal (id_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared immediate extender, same-cycle combinational response
    logic [31:0] ext_i;
    always_comb begin
        ext_i = {imm, 7'b0};
        case (immsrc)
            3'b000:  immext_in = {{20{ext_i[31]}}, ext_i[31:20]};
            3'b001:  immext_in = {{20{ext_i[31]}}, ext_i[31:25], ext_i[11:7]};
            3'b010:  immext_in = {{19{ext_i[31]}}, ext_i[31], ext_i[7], ext_i[30:25], ext_i[11:8], 1'b0};
            3'b011:  immext_in = {{11{ext_i[31]}}, ext_i[31], ext_i[19:12], ext_i[20], ext_i[30:21], 1'b0};
            3'b100:  immext_in = {ext_i[31:12], 12'b0};
            default: immext_in = 32'h0;
        endcase
    end

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_SW   = 32'h0021A423;
    localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
    localparam logic [31:0] I_LUI  = 32'h123452B7;
    localparam logic [31:0] I_BAD  = 32'h0000007F;
    localparam logic [31:0] I_ADD  = 32'h002081B3;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0;
        flush = 1'b0; ex_ready = 1'b0;
        cyc(); cyc();
        vectors++;
        if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_immext !== 32'h0 || id_illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b pc=%h immext=%h illegal=%b, required 0/0/0/0", id_valid, id_pc, id_immext, id_illegal);
        end
        vectors++;
        if (if_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_if_ready: got %b, required 0", if_ready);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (if_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_if_ready: got %b, required 1", if_ready);
        end
    endtask

    task automatic test_basic();
        ex_ready = 1'b1; if_valid = 1'b1; if_instr = I_ADDI; if_pc = 32'h100;
        #1;
        vectors++;
        if (immsrc !== 3'b000) begin
            miscompares++;
            $display("FAIL addi_immsrc: got %b, required 000", immsrc);
        end
        cyc();
        if_valid = 1'b0;
        vectors++;
        if (id_valid !== 1'b1 || id_immext !== 32'h5 || id_rd !== 5'd1 || id_rs1 !== 5'd0 ||
            id_pc !== 32'h100 || id_illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL addi_out: valid=%b immext=%h rd=%0d rs1=%0d pc=%h ill=%b, required 1/00000005/1/0/00000100/0",
                     id_valid, id_immext, id_rd, id_rs1, id_pc, id_illegal);
        end
        cyc();
        vectors++;
        if (id_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL addi_drain: id_valid=%b, required 0", id_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] instrs [3];
        logic [2:0]  srcs   [3];
        logic [31:0] exts   [3];
        instrs[0] = I_SW;  srcs[0] = 3'b001; exts[0] = 32'h00000008;
        instrs[1] = I_BEQ; srcs[1] = 3'b010; exts[1] = 32'hFFFFFFFC;
        instrs[2] = I_LUI; srcs[2] = 3'b100; exts[2] = 32'h12345000;
        ex_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if_valid = 1'b1; if_instr = instrs[k]; if_pc = 32'h140 + 32'(4 * k);
            #1;
            vectors++;
            if (immsrc !== srcs[k]) begin
                miscompares++;
                $display("FAIL b2b_immsrc[%0d]: got %b, required %b", k, immsrc, srcs[k]);
            end
            cyc();
            vectors++;
            if (id_valid !== 1'b1 || id_immext !== exts[k] || id_pc !== 32'h140 + 32'(4 * k)) begin
                miscompares++;
                $display("FAIL b2b_out[%0d]: valid=%b immext=%h pc=%h, required 1/%h/%h",
                         k, id_valid, id_immext, id_pc, exts[k], 32'h140 + 32'(4 * k));
            end
        end
        if_valid = 1'b0;
        cyc();
    endtask

    task automatic test_stall();
        ex_ready = 1'b0; if_valid = 1'b1; if_instr = I_ADDI; if_pc = 32'h200;
        cyc();
        if_instr = I_SW; if_pc = 32'h204;
        #1;
        vectors++;
        if (if_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_ready_busy: got %b, required 1", if_ready);
        end
        cyc();
        if_instr = I_LUI; if_pc = 32'h208;
        #1;
        vectors++;
        if (if_ready !== 1'b0 || immsrc !== 3'b001) begin
            miscompares++;
            $display("FAIL stall_full: if_ready=%b immsrc=%b, required 0/001", if_ready, immsrc);
        end
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_immext !== 32'h5) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h immext=%h, required 1/00000200/00000005",
                         k, id_valid, id_pc, id_immext);
            end
            cyc();
        end
        ex_ready = 1'b1;
        cyc();
        vectors++;
        if (id_valid !== 1'b1 || id_pc !== 32'h204 || id_immext !== 32'h8 || if_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_skid_out: valid=%b pc=%h immext=%h rdy=%b, required 1/00000204/00000008/1",
                     id_valid, id_pc, id_immext, if_ready);
        end
        cyc();
        if_valid = 1'b0;
        vectors++;
        if (id_valid !== 1'b1 || id_pc !== 32'h208 || id_immext !== 32'h12345000) begin
            miscompares++;
            $display("FAIL stall_third: valid=%b pc=%h immext=%h, required 1/00000208/12345000",
                     id_valid, id_pc, id_immext);
        end
        cyc();
        vectors++;
        if (id_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_drain: id_valid=%b, required 0", id_valid);
        end
    endtask

    task automatic test_flush();
        ex_ready = 1'b0; if_valid = 1'b1; if_instr = I_ADDI; if_pc = 32'h300;
        cyc();
        if_instr = I_SW; if_pc = 32'h304;
        cyc();
        flush = 1'b1; if_instr = I_LUI; if_pc = 32'h308;
        cyc();
        flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        vectors++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_full: valid=%b rdy=%b, required 0/1", id_valid, if_ready);
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            vectors++;
            if (id_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_no_emit[%0d]: id_valid=%b pc=%h, required 0", k, id_valid, id_pc);
            end
        end
        // flush in BUSY drops a same-cycle accept while if_ready stays high
        if_valid = 1'b1; if_instr = I_ADDI; if_pc = 32'h310;
        cyc();
        flush = 1'b1; if_instr = I_SW; if_pc = 32'h314;
        #1;
        vectors++;
        if (if_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_busy_ready: got %b, required 1", if_ready);
        end
        cyc();
        flush = 1'b0; if_valid = 1'b0;
        vectors++;
        if (id_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_busy_drop: id_valid=%b pc=%h, required 0", id_valid, id_pc);
        end
    endtask

    task automatic test_illegal();
        ex_ready = 1'b1; if_valid = 1'b1; if_instr = I_BAD; if_pc = 32'h400;
        #1;
        vectors++;
        if (immsrc !== 3'b111) begin
            miscompares++;
            $display("FAIL bad_immsrc: got %b, required 111", immsrc);
        end
        cyc();
        if_instr = I_ADD; if_pc = 32'h404;
        vectors++;
        if (id_valid !== 1'b1 || id_illegal !== 1'b1 || id_immext !== 32'h0) begin
            miscompares++;
            $display("FAIL bad_out: valid=%b ill=%b immext=%h, required 1/1/00000000", id_valid, id_illegal, id_immext);
        end
        cyc();
        if_valid = 1'b0;
        vectors++;
        if (id_illegal !== 1'b0 || id_immext !== 32'h0 || id_rd !== 5'd3 || id_rs1 !== 5'd1 || id_rs2 !== 5'd2) begin
            miscompares++;
            $display("FAIL rtype_out: ill=%b immext=%h rd=%0d rs1=%0d rs2=%0d, required 0/00000000/3/1/2",
                     id_illegal, id_immext, id_rd, id_rs1, id_rs2);
        end
        cyc();
    endtask

    task automatic test_reset_full();
        ex_ready = 1'b0; if_valid = 1'b1; if_instr = I_ADDI; if_pc = 32'h500;
        cyc();
        if_instr = I_SW; if_pc = 32'h504;
        cyc();
        rst = 1'b1;
        #1;
        vectors++;
        if (if_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rstfull_ready_during: got %b, required 0", if_ready);
        end
        cyc();
        vectors++;
        if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_immext !== 32'h0 || id_rd !== 5'd0 ||
            id_rs1 !== 5'd0 || id_rs2 !== 5'd0 || id_illegal !== 1'b0 || if_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rstfull_outputs: valid=%b pc=%h immext=%h rd=%0d rs1=%0d rs2=%0d ill=%b rdy=%b, required all 0",
                     id_valid, id_pc, id_immext, id_rd, id_rs1, id_rs2, id_illegal, if_ready);
        end
        cyc();
        rst = 1'b0; ex_ready = 1'b1; if_instr = I_LUI; if_pc = 32'h600;
        #1;
        vectors++;
        if (if_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rstfull_ready_after: got %b, required 1", if_ready);
        end
        cyc();
        if_valid = 1'b0;
        vectors++;
        if (id_valid !== 1'b1 || id_pc !== 32'h600 || id_immext !== 32'h12345000) begin
            miscompares++;
            $display("FAIL rstfull_next: valid=%b pc=%h immext=%h, required 1/00000600/12345000",
                     id_valid, id_pc, id_immext);
        end
        cyc();
        vectors++;
        if (id_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rstfull_drain: id_valid=%b, required 0", id_valid);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_flush();
        test_illegal();
        test_reset_full();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_stage_seq.md
# id_stage_seq

Decode-stage sequencer for the in-order RISC-V pipeline. It accepts fetched instructions over a valid/ready handshake and classifies each opcode into an immediate format. It drives the shared immediate extender (`immsrc`, `imm`) and captures the extender's result plus register fields into the ID/EX output register. A one-entry skid buffer keeps `if_ready` free of any combinational path from `ex_ready`.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_valid`  in  1  fetch offers an instruction
- `if_instr`  in  32  instruction word
- `if_pc`  in  32  PC of the instruction
- `if_ready`  out  1  block accepts this cycle; equals `!rst && state!=FULL`
- `flush`  in  1  synchronous kill of all held instructions (branch redirect)
- `immsrc`  out  3  format select to the extender
- `imm`  out  25  `instr[31:7]` of the instruction being loaded into the output register
- `immext_in`  in  32  extender result for the current `immsrc`/`imm`, same cycle
- `id_valid`  out  1  output register holds a live instruction
- `ex_ready`  in  1  execute stage consumes the output register this cycle
- `id_pc`  out  32  registered PC
- `id_immext`  out  32  registered extended immediate
- `id_rd`, `id_rs1`, `id_rs2`  out  5 each  registered `instr[11:7]`, `[19:15]`, `[24:20]`
- `id_illegal`  out  1  registered unknown-opcode flag

## Operation
- Opcode to `immsrc` mapping:
  - 0000011, 0010011, 1100111 → 000 (I)
  - 0100011 → 001 (S)
  - 1100011 → 010 (B)
  - 1101111 → 011 (J)
  - 0110111, 0010111 → 100 (U)
  - 0110011 → 111; extender returns 0, so `id_immext` = 0
  - any other opcode → 111, and `id_illegal` = 1
- Load source: the skid entry when the skid is full, otherwise `if_instr`/`if_pc`. `immsrc` and `imm` are decoded combinationally from that source every cycle.
- accept = `if_valid && if_ready`. consume = `id_valid && ex_ready`.
- State machine:
  - EMPTY: output invalid, skid empty.
  - BUSY: output valid, skid empty.
  - FULL: output valid, skid full.
- Transitions:
  - EMPTY + accept → BUSY; output loaded from input.
  - BUSY + accept + consume → BUSY; output reloaded from input.
  - BUSY + accept + !consume → FULL; input raw word and PC stored in skid.
  - BUSY + !accept + consume → EMPTY.
  - BUSY + neither → BUSY; output held.
  - FULL + consume → BUSY; skid moved to output, re-extended via extender.
  - FULL + !consume → FULL; everything held.
- Output fields never change while `id_valid && !ex_ready`.
- Skid stores the raw 32-bit instruction and PC, not the extended value. The extender is therefore time-shared between the fetch path and the skid path.
- `flush` has priority over everything except `rst`: state → EMPTY, `id_valid` → 0, and any same-cycle accept is dropped. `if_ready` is still 1 in that cycle (state is not FULL), so fetch must redirect.

## Timing
- Latency: instruction accepted in cycle N appears with `id_valid`=1 in cycle N+1.
- Throughput: 1 instruction/cycle while `ex_ready`=1.
- Deassertion of `if_ready` is registered: it goes low the cycle after the skid fills. It never depends combinationally on `ex_ready`.
- Reset (`rst`=1 at an edge): state EMPTY, skid cleared. `id_valid`, `id_pc`, `id_immext`, `id_rd`, `id_rs1`, `id_rs2`, `id_illegal` are all 0.
- During reset: `if_ready`=0, and handshakes are ignored.
- Reset asserted mid-stall (FULL) discards both entries. `if_ready`=1 in the first cycle after `rst` drops.
- Simultaneous `flush` and `rst`: reset behaviour.

## Test plan
- Reset, then offer `0x00500093` (addi x1,x0,5) at PC `0x100` → next cycle `id_valid`=1, `id_immext`=`0x00000005`, `id_rd`=1, `id_rs1`=0, `id_pc`=`0x100`, `id_illegal`=0.
- Stream back-to-back with `ex_ready`=1: `0x0021A423` (sw), `0xFE000EE3` (beq), `0x123452B7` (lui).
  - `id_immext` = `0x00000008`, `0xFFFFFFFC`, `0x12345000` on consecutive cycles.
  - `immsrc` = 001, 010, 100 in the cycle each is loaded.
- Hold `ex_ready`=0 with `if_valid`=1 continuously.
  - Second instruction lands in skid; `if_ready` drops the cycle after; output is stable.
  - Release `ex_ready` → skid instruction emerges with the correct `id_immext`. No instruction is lost or duplicated.
- In FULL, assert `flush` for one cycle → `id_valid`=0 next cycle, state EMPTY, `if_ready`=1, and neither held instruction is ever emitted.
- Offer opcode `0x0000007F` → `id_illegal`=1, `id_immext`=0. Offer R-type `0x002081B3` → `id_illegal`=0, `id_immext`=0.
- Assert `rst` while FULL with `if_valid`=1 → all outputs 0 and `if_ready`=0 during reset. The first instruction accepted afterward is the next one emitted.
